// File: rtl/mw8080_mem_arbiter.sv
// rtl/mw8080_mem_arbiter.sv - shared ROM/RAM access sequencer for CPU and video fetch
//
// Arbitrates the Midway-Taito 8080 memory block between the CPU bus and the
// video shifter. Video has priority; after MAX_VID_BURST consecutive video
// grants with the CPU waiting, the CPU is served next.
//
// Ports:
//   Clock, Reset_n              clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata          CPU completion pulse and held read data
//   vid_req/addr                video fetch request (read only, RAM offset)
//   vid_ack, vid_rdata          video completion pulse and held fetched byte
//   Addr, Ram_Addr, Ram_in      registered address/data to the memory block
//   RW_n                        RAM write strobe, active low, one ACCESS cycle
//   Ram_out, Rom_out            registered memory read data
//   busy                        high whenever not IDLE
module mw8080_mem_arbiter #(
  parameter int unsigned MAX_VID_BURST = 4,
  parameter logic [15:0] RAM_BASE      = 16'h2000,
  parameter logic [15:0] RAM_LAST      = 16'h3FFF
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  output logic [15:0] Addr,
  output logic [15:0] Ram_Addr,
  output logic [7:0]  Ram_in,
  output logic        RW_n,
  input  logic [7:0]  Ram_out,
  input  logic [7:0]  Rom_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_e;

  localparam int BW = $clog2(MAX_VID_BURST + 1);

  state_e        state_q, state_d;
  logic          sel_cpu_q, sel_cpu_d;     // owner of the access in flight
  logic          we_q, we_d;
  logic          in_ram_q, in_ram_d;       // CPU address decoded as RAM
  logic [15:0]   addr_q, addr_d;
  logic [12:0]   ram_addr_q, ram_addr_d;
  logic [7:0]    ram_in_q, ram_in_d;
  logic          rw_n_q, rw_n_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          vid_ack_q, vid_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    vid_rdata_q, vid_rdata_d;
  logic [BW-1:0] burst_q, burst_d;

  logic          cpu_in_ram;
  logic [12:0]   cpu_ofs;
  logic          burst_full;
  logic          grant_vid;
  logic          grant_cpu;

  assign cpu_in_ram = (cpu_addr >= RAM_BASE) && (cpu_addr <= RAM_LAST);
  // Only the low 13 bits of the offset matter; they depend only on low operand bits.
  assign cpu_ofs    = cpu_addr[12:0] - RAM_BASE[12:0];
  assign burst_full = (burst_q == BW'(MAX_VID_BURST));
  assign grant_vid  = vid_req && !(cpu_req && burst_full);
  assign grant_cpu  = cpu_req && !grant_vid;

  always_comb begin
    state_d     = state_q;
    sel_cpu_d   = sel_cpu_q;
    we_d        = we_q;
    in_ram_d    = in_ram_q;
    addr_d      = addr_q;
    ram_addr_d  = ram_addr_q;
    ram_in_d    = ram_in_q;
    rw_n_d      = 1'b1;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    burst_d     = burst_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vid) begin
          state_d    = ACCESS;
          sel_cpu_d  = 1'b0;
          we_d       = 1'b0;
          in_ram_d   = 1'b1;
          ram_addr_d = vid_addr;
          // Count only grants that made a waiting CPU wait longer.
          if (!cpu_req)        burst_d = '0;
          else if (!burst_full) burst_d = burst_q + BW'(1);
        end else if (grant_cpu) begin
          state_d   = ACCESS;
          sel_cpu_d = 1'b1;
          we_d      = cpu_we;
          in_ram_d  = cpu_in_ram;
          addr_d    = cpu_addr;
          burst_d   = '0;
          if (cpu_in_ram) ram_addr_d = cpu_ofs;
          if (cpu_we && cpu_in_ram) begin
            ram_in_d = cpu_wdata;
            // Strobe is registered so it is low for exactly the ACCESS cycle.
            rw_n_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (sel_cpu_q && we_q) begin
          cpu_ack_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        if (sel_cpu_q) begin
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = in_ram_q ? Ram_out : Rom_out;
        end else begin
          vid_ack_d   = 1'b1;
          vid_rdata_d = Ram_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      sel_cpu_q   <= 1'b0;
      we_q        <= 1'b0;
      in_ram_q    <= 1'b0;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      ram_in_q    <= '0;
      rw_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_cpu_q   <= sel_cpu_d;
      we_q        <= we_d;
      in_ram_q    <= in_ram_d;
      addr_q      <= addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_in_q    <= ram_in_d;
      rw_n_q      <= rw_n_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      burst_q     <= burst_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign vid_rdata = vid_rdata_q;
  assign Addr      = addr_q;
  assign Ram_Addr  = {3'b000, ram_addr_q};
  assign Ram_in    = ram_in_q;
  assign RW_n      = rw_n_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mw8080_mem_arbiter.sv
// tb/tb_mw8080_mem_arbiter.sv - scoreboard bench for mw8080_mem_arbiter
module tb_mw8080_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req = 1'b0;
  logic [12:0] vid_addr = '0;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic [15:0] Addr, Ram_Addr;
  logic [7:0]  Ram_in;
  logic        RW_n;
  logic [7:0]  Ram_out, Rom_out;
  logic        busy;

  mw8080_mem_arbiter dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .Addr(Addr), .Ram_Addr(Ram_Addr), .Ram_in(Ram_in), .RW_n(RW_n),
    .Ram_out(Ram_out), .Rom_out(Rom_out), .busy(busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Memory block model: registered reads, RAM written while RW_n is low.
  logic [7:0] ram [0:8191];
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  always @(posedge Clock) begin
    if (!RW_n) ram[Ram_Addr[12:0]] <= Ram_in;
    Ram_out <= ram[Ram_Addr[12:0]];
    Rom_out <= rom_byte(Addr);
  end

  typedef struct {
    logic       is_vid;
    logic       chk;
    logic [7:0] data;
    int         ack_cyc;   // 0 = latency not checked
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops one expected completion.
  always @(negedge Clock) begin
    if (cpu_ack || vid_ack) begin
      if (cpu_ack && vid_ack) check("dual_ack", 32'd1, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_ack", {30'd0, vid_ack, cpu_ack}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ack_source", {31'd0, vid_ack}, {31'd0, e.is_vid});
        if (e.chk) check(e.is_vid ? "vid_rdata" : "cpu_rdata",
                         {24'd0, (vid_ack ? vid_rdata : cpu_rdata)}, {24'd0, e.data});
        if (e.ack_cyc != 0) check("ack_latency", cyc, e.ack_cyc);
      end
    end
  end

  function automatic exp_t mk(input logic v, input logic c, input logic [7:0] d, input int ac);
    exp_t e;
    e.is_vid = v; e.chk = c; e.data = d; e.ack_cyc = ac;
    return e;
  endfunction

  // sel: 0 = cpu_ack, 1 = vid_ack, 2 = either
  task automatic wait_ack(input int sel, input string name);
    int n;
    logic hit;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
      hit = (sel == 0) ? cpu_ack : (sel == 1) ? vid_ack : (cpu_ack | vid_ack);
    end while (!hit && n < 40);
    check(name, {31'd0, hit}, 32'd1);
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] wd,
                        input logic chk, input logic [7:0] ed, input int lat,
                        output int rw_low, output logic [15:0] ram_a, output logic [15:0] addr_seen);
    int n;
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    q.push_back(mk(1'b0, chk, ed, cyc + lat));
    rw_low = 0; ram_a = 16'hFFFF; addr_seen = 16'hFFFF; n = 0;
    do begin
      @(negedge Clock);
      n++;
      if (n == 1) addr_seen = Addr;
      if (!RW_n) begin rw_low++; ram_a = Ram_Addr; end
    end while (!cpu_ack && n < 20);
    check("cpu_ack_seen", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic vid_op(input logic [12:0] a, input logic [7:0] ed, input int lat);
    vid_addr = a; vid_req = 1'b1;
    q.push_back(mk(1'b1, 1'b1, ed, cyc + lat));
    wait_ack(1, "vid_ack_seen");
    vid_req = 1'b0;
  endtask

  int rw_low;
  logic [15:0] ram_a, addr_seen;
  int c0;

  initial begin
    // Reset state
    repeat (3) @(negedge Clock);
    check("reset_outputs",
          {cpu_ack, vid_ack, cpu_rdata, vid_rdata, Ram_in, RW_n, busy},
          {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0});
    check("reset_addr", {Addr, Ram_Addr}, 32'h0);
    Reset_n = 1'b1;
    @(negedge Clock);

    // Seed old value, then abort a write to the same byte with reset
    cpu_op(1'b1, 16'h2400, 8'h11, 1'b0, 8'h00, 2, rw_low, ram_a, addr_seen);
    check("seed_rw_low_cycles", rw_low, 1);
    @(negedge Clock);
    cpu_we = 1'b1; cpu_addr = 16'h2400; cpu_wdata = 8'h99; cpu_req = 1'b1;
    @(negedge Clock);
    check("rwn_low_in_access", {31'd0, RW_n}, 32'd0);
    Reset_n = 1'b0;
    #1;
    check("rwn_async_clear", {31'd0, RW_n}, 32'd1);
    check("busy_async_clear", {31'd0, busy}, 32'd0);
    cpu_req = 1'b0;
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    cpu_op(1'b0, 16'h2400, 8'h00, 1'b1, 8'h11, 3, rw_low, ram_a, addr_seen);
    @(negedge Clock);

    // CPU write then read
    cpu_op(1'b1, 16'h2400, 8'h5A, 1'b0, 8'h00, 2, rw_low, ram_a, addr_seen);
    check("write_rw_low_cycles", rw_low, 1);
    check("write_ram_addr", {16'd0, ram_a}, 32'h0400);
    @(negedge Clock);
    cpu_op(1'b0, 16'h2400, 8'h00, 1'b1, 8'h5A, 3, rw_low, ram_a, addr_seen);
    check("read_rw_low_cycles", rw_low, 0);
    @(negedge Clock);

    // ROM read, then write to ROM space (acked, no strobe, rdata held)
    cpu_op(1'b0, 16'h4003, 8'h00, 1'b1, 8'h7F, 3, rw_low, ram_a, addr_seen);
    check("rom_addr", {16'd0, addr_seen}, 32'h4003);
    check("rom_rw_low_cycles", rw_low, 0);
    @(negedge Clock);
    cpu_op(1'b1, 16'h0100, 8'hEE, 1'b1, 8'h7F, 2, rw_low, ram_a, addr_seen);
    check("romwr_rw_low_cycles", rw_low, 0);
    @(negedge Clock);

    // Top of RAM written by CPU, fetched by video
    cpu_op(1'b1, 16'h3FFF, 8'hC3, 1'b0, 8'h00, 2, rw_low, ram_a, addr_seen);
    check("top_ram_addr", {16'd0, ram_a}, 32'h1FFF);
    @(negedge Clock);
    vid_op(13'h1FFF, 8'hC3, 3);
    @(negedge Clock);

    // Video only, request held: a grant every 3 cycles
    vid_addr = 13'h0400; vid_req = 1'b1; c0 = cyc;
    for (int k = 1; k <= 3; k++) q.push_back(mk(1'b1, 1'b1, 8'h5A, c0 + 3 * k));
    for (int k = 0; k < 3; k++) wait_ack(1, "vid_burst_ack");
    vid_req = 1'b0;
    @(negedge Clock);

    // Contention, both held: V,V,V,V,C,V,V,V,V,C
    vid_addr = 13'h1FFF; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 16'h2400; cpu_req = 1'b1; c0 = cyc;
    for (int k = 1; k <= 10; k++) begin
      if (k % 5 == 0) q.push_back(mk(1'b0, 1'b1, 8'h5A, c0 + 3 * k));
      else            q.push_back(mk(1'b1, 1'b1, 8'hC3, c0 + 3 * k));
    end
    for (int k = 0; k < 10; k++) wait_ack(2, "contention_ack");
    vid_req = 1'b0; cpu_req = 1'b0;
    @(negedge Clock);

    // Simultaneous first request: video first, CPU 3 cycles later
    vid_addr = 13'h1FFF; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 16'h4003; cpu_req = 1'b1; c0 = cyc;
    q.push_back(mk(1'b1, 1'b1, 8'hC3, c0 + 3));
    q.push_back(mk(1'b0, 1'b1, 8'h7F, c0 + 6));
    wait_ack(1, "simul_vid_ack");
    vid_req = 1'b0;
    wait_ack(0, "simul_cpu_ack");
    cpu_req = 1'b0;

    repeat (5) @(negedge Clock);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mw8080_mem_arbiter.md
Name: mw8080_mem_arbiter

Overview:
Sequences all accesses to the shared program-ROM / 8 KB work-and-video-RAM memory block of the Midway-Taito 8080 cores. It arbitrates between the CPU bus interface and the video shifter fetch unit. It drives the memory block's Addr, Ram_Addr, Ram_in and RW_n inputs, and returns registered read data with a one-cycle ack pulse. Video has priority, with a bounded-burst starvation guard for the CPU.

Parameters:
MAX_VID_BURST, 4, consecutive video grants allowed while a CPU request is pending; the CPU is granted next.
RAM_BASE, 16'h2000, first CPU address decoded as RAM.
RAM_LAST, 16'h3FFF, last CPU address decoded as RAM.

Ports:
Clock  in  1  system clock; all state updates on the rising edge.
Reset_n  in  1  asynchronous, active-low reset.
cpu_req  in  1  CPU access request; level, held until cpu_ack.
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
cpu_addr  in  16  CPU byte address.
cpu_wdata  in  8  CPU write data.
cpu_ack  out  1  one-cycle completion pulse.
cpu_rdata  out  8  read data; valid in the cpu_ack cycle and held until the next CPU read completes.
vid_req  in  1  video fetch request (read only); level, held until vid_ack.
vid_addr  in  13  RAM offset, 0x0000-0x1FFF.
vid_ack  out  1  one-cycle completion pulse.
vid_rdata  out  8  fetched byte; held until the next video completion.
Addr  out  16  to the memory block ROM address.
Ram_Addr  out  16  to the memory block RAM address; bits 15:13 are always 0.
Ram_in  out  8  RAM write data.
RW_n  out  1  RAM write strobe, active low.
Ram_out  in  8  RAM read data; registered, valid one cycle after the address edge.
Rom_out  in  8  ROM read data; same timing as Ram_out.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous: state = IDLE; all outputs 0 except RW_n = 1; burst counter = 0.
- A reset asserted mid-access aborts the access with no ack. RW_n must return high immediately (asynchronous clear).
- States: IDLE, ACCESS, CAPTURE.
- IDLE: requests are sampled at the rising edge.
  - If vid_req and cpu_req are both high, video wins unless burst counter = MAX_VID_BURST, in which case the CPU wins.
  - The selected address is registered onto Addr / Ram_Addr.
  - For a CPU write to RAM, Ram_in is registered as well.
  - Next state is ACCESS. With no request, remain in IDLE.
- ACCESS, one cycle:
  - RW_n = 0 only for a CPU write whose address is in [RAM_BASE, RAM_LAST].
  - CPU write: the cycle ends with cpu_ack pulsed high in the following cycle, and next state is IDLE.
  - Read: next state is CAPTURE.
- CAPTURE, one cycle: at the edge ending CAPTURE, the data is latched and the matching ack is high for the following cycle. Next state is IDLE.
  - Video read: latch Ram_out.
  - CPU read in the RAM range: latch Ram_out.
  - Other CPU read: latch Rom_out.
- CPU address translation:
  - RAM range: Ram_Addr = {3'b0, cpu_addr - RAM_BASE}[12:0].
  - Always: Addr = cpu_addr.
  - Video: Ram_Addr = {3'b0, vid_addr}; Addr is unchanged.
- CPU write outside the RAM range (ROM or unmapped): RW_n stays 1, nothing is written, and the access is still acked. cpu_rdata is unchanged.
- Latency from the request-sampling edge to the ack-high cycle: read = 3 cycles, write = 2 cycles. The ack cycle coincides with the return to IDLE.
- Throughput: a request still held high in the ack cycle is treated as a new request, so requesters must drop req in the ack cycle. Maximum throughput is one read per 3 cycles.
- Burst counter:
  - Increments on each video grant made while cpu_req is high, saturating at MAX_VID_BURST.
  - Clears on any CPU grant and whenever cpu_req is low at a grant.
- Outside ACCESS, RW_n = 1.
- Ram_in holds its last value; it is don't-care for reads.

Test Plan:
- Reset mid-write: assert Reset_n low during ACCESS of a CPU write to 0x2400 -> RW_n = 1 within the same cycle, no cpu_ack, and a later read of 0x2400 returns the old value.
- CPU write then read: write 0x2400 = 0x5A -> cpu_ack 2 cycles after the sample edge, with RW_n low exactly one cycle and Ram_Addr = 0x0400. Read 0x2400 -> cpu_rdata = 0x5A, cpu_ack 3 cycles after the sample edge.
- ROM read: cpu_addr = 0x4003 with a preloaded ROM -> cpu_rdata = Rom_out byte, Addr = 0x4003, RW_n never low. A write to 0x0100 -> acked, RW_n stays 1.
- Video fetch: vid_addr = 0x1FFF after a CPU write of 0xC3 to 0x3FFF -> vid_rdata = 0xC3, vid_ack 3 cycles after the sample edge.
- Contention: vid_req and cpu_req held continuously (re-raised after each ack) -> grant order V,V,V,V,C,V,V,V,V,C. cpu_req low -> video-only back-to-back grants every 3 cycles.
- Simultaneous first request with counter = 0 -> video served first, and the CPU is acked 3 cycles after vid_ack.
